// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared defaults and state encoding for the fetch sequencer
package pc_sequencer_pkg;

   localparam int          PC_W_DEFAULT        = 32;
   localparam int          INSTR_BYTES_DEFAULT = 4;
   localparam int          RAS_DEPTH_DEFAULT   = 8;
   localparam int unsigned RESET_PC_DEFAULT    = 32'h0;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-fetch handshake and execute-resolution bundle
interface pc_sequencer_if
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W = PC_W_DEFAULT
);

   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_gnt;

   logic            exec_valid;
   logic            is_branch_taken;
   logic            is_call;
   logic            is_ret;
   logic            is_halt;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] ret_fallback;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt,
      input  exec_valid, is_branch_taken, is_call, is_ret, is_halt,
      input  branch_target, ret_fallback
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt,
      output exec_valid, is_branch_taken, is_call, is_ret, is_halt,
      output branch_target, ret_fallback
   );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// rtl/pc_sequencer_ras_stack.sv - circular return-address LIFO; a push when full drops the oldest entry
module pc_sequencer_ras_stack
   import pc_sequencer_pkg::*;
#(
   parameter int DATA_W = PC_W_DEFAULT,
   parameter int DEPTH  = RAS_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        push_data,
   output logic [DATA_W-1:0]        top,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_pop, do_push;

   assign full   = (count_q == CNT_W'(DEPTH));
   assign empty  = (count_q == '0);
   assign rd_ptr = wr_ptr_q - PTR_W'(1);
   assign top    = mem_q[rd_ptr];
   assign count  = count_q;

   // A valid pop wins over a simultaneous push; empty pops are ignored here.
   assign do_pop  = pop && !empty;
   assign do_push = push && !do_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop) begin
         wr_ptr_d = rd_ptr;
         count_d  = count_q - CNT_W'(1);
      end else if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (!full) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - BOOT/FETCH/EXEC/HALT program-counter sequencer with return-address stack
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              PC_W        = PC_W_DEFAULT,
   parameter int              INSTR_BYTES = INSTR_BYTES_DEFAULT,
   parameter int              RAS_DEPTH   = RAS_DEPTH_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC    = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic                        clk,
   input  logic                        reset,
   pc_sequencer_if.master              bus,
   input  logic                        stall,
   output logic [PC_W-1:0]             pc,
   output logic                        issue,
   output logic                        halted,
   output logic [$clog2(RAS_DEPTH):0]  ras_count,
   output logic                        ras_overflow,
   output logic                        ras_underflow
);

   seq_state_e      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            req_pend_q, req_pend_d;
   logic            issue_q, issue_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;

   logic            imem_req;
   logic [PC_W-1:0] pc_seq;
   logic            ras_push, ras_pop, ras_full, ras_empty;
   logic [PC_W-1:0] ras_top;

   assign pc_seq = pc_q + PC_W'(INSTR_BYTES);

   // Stall only gates a request that has not been presented yet.
   assign imem_req = (state_q == S_FETCH) && (req_pend_q || !stall);

   assign bus.imem_req  = imem_req;
   assign bus.imem_addr = pc_q;
   assign pc            = pc_q;
   assign issue         = issue_q;
   assign halted        = (state_q == S_HALT);
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

   pc_sequencer_ras_stack #(
      .DATA_W (PC_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_seq),
      .top       (ras_top),
      .count     (ras_count),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pend_d = req_pend_q;
      issue_d    = 1'b0;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      ras_push   = 1'b0;
      ras_pop    = 1'b0;
      unique case (state_q)
         S_BOOT: state_d = S_FETCH;
         S_FETCH: begin
            if (imem_req) begin
               if (bus.imem_gnt) begin
                  state_d    = S_EXEC;
                  req_pend_d = 1'b0;
                  issue_d    = 1'b1;
               end else begin
                  req_pend_d = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (bus.exec_valid) begin
               state_d = S_FETCH;
               // Priority: halt, ret, call, taken branch, sequential.
               if (bus.is_halt) begin
                  state_d = S_HALT;
               end else if (bus.is_ret) begin
                  if (!ras_empty) begin
                     ras_pop = 1'b1;
                     pc_d    = ras_top;
                  end else begin
                     pc_d  = bus.ret_fallback;
                     unf_d = 1'b1;
                  end
               end else if (bus.is_call) begin
                  ras_push = 1'b1;
                  pc_d     = bus.branch_target;
                  if (ras_full) begin
                     ovf_d = 1'b1;
                  end
               end else if (bus.is_branch_taken) begin
                  pc_d = bus.branch_target;
               end else begin
                  pc_d = pc_seq;
               end
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         req_pend_q <= 1'b0;
         issue_q    <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pend_q <= req_pend_d;
         issue_q    <= issue_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a queue-based model
module tb_pc_sequencer;

   localparam int PC_W  = 32;
   localparam int DEPTH = 4;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     stall = 1'b0;
   logic [PC_W-1:0]          pc;
   logic                     issue;
   logic                     halted;
   logic [$clog2(DEPTH):0]   ras_count;
   logic                     ras_overflow;
   logic                     ras_underflow;

   pc_sequencer_if #(.PC_W(PC_W)) bus ();

   pc_sequencer #(
      .PC_W        (PC_W),
      .INSTR_BYTES (4),
      .RAS_DEPTH   (DEPTH),
      .RESET_PC    (32'h0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .stall         (stall),
      .pc            (pc),
      .issue         (issue),
      .halted        (halted),
      .ras_count     (ras_count),
      .ras_overflow  (ras_overflow),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   bit          m_ovf;
   bit          m_unf;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic clear_exec();
      bus.exec_valid      = 1'b0;
      bus.is_branch_taken = 1'b0;
      bus.is_call         = 1'b0;
      bus.is_ret          = 1'b0;
      bus.is_halt         = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check_eq({tag, "_pc"}, pc, m_pc);
      check_eq({tag, "_cnt"}, 32'(ras_count), m_ras.size());
      check_eq({tag, "_ovf"}, ras_overflow, m_ovf);
      check_eq({tag, "_unf"}, ras_underflow, m_unf);
   endtask

   // Entered at negedge+1; leaves at negedge+1 of the first EXEC cycle.
   task automatic fetch(input int gnt_delay, input bit shake);
      int n = 0;
      bus.imem_gnt = 1'b0;
      while (bus.imem_req !== 1'b1 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check_eq("req_seen", bus.imem_req, 1);
      check_eq("fetch_addr", bus.imem_addr, m_pc);
      for (int i = 0; i < gnt_delay; i++) begin
         @(negedge clk);
         if (shake) begin
            stall               = 1'($urandom_range(0, 1));
            bus.exec_valid      = 1'($urandom_range(0, 1));
            bus.is_branch_taken = 1'b1;
            bus.is_halt         = 1'($urandom_range(0, 1));
            bus.branch_target   = $urandom & ~32'h3;
         end
         #1;
         check_eq("req_hold", bus.imem_req, 1);
         check_eq("addr_hold", bus.imem_addr, m_pc);
         check_eq("no_issue", issue, 0);
      end
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      stall = 1'b0;
      clear_exec();
      #1;
      check_eq("issue", issue, 1);
      check_eq("exec_req", bus.imem_req, 0);
   endtask

   task automatic exec_op(input int wait_cyc, input bit br, input bit call, input bit ret,
                          input bit halt, input logic [31:0] tgt, input logic [31:0] fb,
                          input int stall_cyc);
      for (int i = 0; i < wait_cyc; i++) begin
         @(negedge clk); #1;
         check_eq("exec_wait_issue", issue, 0);
         check_eq("exec_wait_req", bus.imem_req, 0);
      end
      bus.exec_valid      = 1'b1;
      bus.is_branch_taken = br;
      bus.is_call         = call;
      bus.is_ret          = ret;
      bus.is_halt         = halt;
      bus.branch_target   = tgt;
      bus.ret_fallback    = fb;
      stall               = (stall_cyc > 0);
      if (!halt) begin
         if (ret) begin
            if (m_ras.size() > 0) begin
               m_pc = m_ras.pop_back();
            end else begin
               m_pc  = fb;
               m_unf = 1'b1;
            end
         end else if (call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1'b1;
            end
            m_pc = tgt;
         end else if (br) begin
            m_pc = tgt;
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
      clear_exec();
      #1;
      if (halt) begin
         check_eq("halted", halted, 1);
         check_eq("halt_req", bus.imem_req, 0);
      end else begin
         if (stall_cyc > 0) begin
            check_eq("stall_entry_req", bus.imem_req, 0);
            for (int i = 1; i < stall_cyc; i++) begin
               @(negedge clk); #1;
               check_eq("stall_wait_req", bus.imem_req, 0);
            end
            stall = 1'b0;
            #1;
         end
         check_eq("next_req", bus.imem_req, 1);
         check_eq("next_addr", bus.imem_addr, m_pc);
         check_eq("not_halted", halted, 0);
      end
      check_model("exec");
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
      check_eq("boot_req", bus.imem_req, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] tgt;
      int r;
      clear_exec();
      bus.imem_gnt      = 1'b0;
      bus.branch_target = '0;
      bus.ret_fallback  = '0;
      model_reset();

      // Reset values
      #12;
      check_eq("rst_req", bus.imem_req, 0);
      check_eq("rst_issue", issue, 0);
      check_eq("rst_halted", halted, 0);
      check_model("rst");

      // Boot with gnt tied high: 0x0, 0x4, 0x8
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("boot_req", bus.imem_req, 0);
      @(negedge clk); #1;
      check_eq("first_req", bus.imem_req, 1);
      check_eq("first_addr", bus.imem_addr, 32'h0);
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      #1;
      check_eq("first_issue", issue, 1);
      exec_op(0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("seq_addr4", bus.imem_addr, 32'h4);
      fetch(0, 0);
      exec_op(0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("seq_addr8", bus.imem_addr, 32'h8);

      // Long grant wait with stall toggling, then call/ret pair
      fetch(5, 1);
      exec_op(1, 1, 0, 0, 0, 32'h100, 0, 0);
      fetch(1, 0);
      exec_op(0, 0, 1, 0, 0, 32'h400, 0, 0);
      check_eq("call_addr", bus.imem_addr, 32'h400);
      check_eq("call_cnt", 32'(ras_count), 1);
      fetch(0, 0);
      exec_op(0, 0, 0, 1, 0, 0, 32'h999C, 0);
      check_eq("ret_addr", bus.imem_addr, 32'h104);
      check_eq("ret_cnt", 32'(ras_count), 0);

      // Five nested calls then five rets on a 4-deep stack
      for (int i = 1; i <= 5; i++) begin
         fetch($urandom_range(0, 2), 1);
         exec_op(0, 0, 1, 0, 0, 32'(i) << 12, 0, 0);
      end
      check_eq("ovf_set", ras_overflow, 1);
      for (int i = 1; i <= 5; i++) begin
         fetch(0, 0);
         exec_op(0, 0, 0, 1, 0, 0, 32'h55C, 0);
      end
      check_eq("ret5_addr", bus.imem_addr, 32'h55C);
      check_eq("unf_set", ras_underflow, 1);

      // PC wrap and a plain taken branch
      fetch(0, 0);
      exec_op(0, 1, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
      fetch(0, 0);
      exec_op(0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("wrap_addr", bus.imem_addr, 32'h0);
      fetch(0, 0);
      exec_op(0, 1, 0, 0, 0, 32'h20, 0, 0);
      check_eq("br_addr", bus.imem_addr, 32'h20);

      // Randomized instruction stream
      for (int k = 0; k < 120; k++) begin
         r   = $urandom_range(0, 99);
         tgt = $urandom & ~32'h3;
         fetch($urandom_range(0, 3), 1);
         if (r < 35)      exec_op($urandom_range(0, 2), 0, 0, 0, 0, tgt, $urandom & ~32'h3, 0);
         else if (r < 55) exec_op($urandom_range(0, 2), 1, 0, 0, 0, tgt, $urandom & ~32'h3, 0);
         else if (r < 75) exec_op($urandom_range(0, 2), 0, 1, 0, 0, tgt, $urandom & ~32'h3, 0);
         else if (r < 92) exec_op($urandom_range(0, 2), 0, 0, 1, 0, tgt, $urandom & ~32'h3, 0);
         else if (r < 96) exec_op($urandom_range(0, 2), 0, 1, 1, 0, tgt, $urandom & ~32'h3, 0);
         else             exec_op($urandom_range(0, 2), 1, 1, 0, 0, tgt, $urandom & ~32'h3, 0);
         if ($urandom_range(0, 4) == 0) begin
            fetch(0, 0);
            exec_op(0, 0, 0, 0, 0, 0, 0, $urandom_range(1, 3));
         end
      end

      // Halt at 0x40 and stay there
      fetch(0, 0);
      exec_op(0, 1, 0, 0, 0, 32'h40, 0, 0);
      fetch(2, 1);
      exec_op(0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.imem_gnt        = 1'b1;
         stall               = 1'($urandom_range(0, 1));
         bus.exec_valid      = 1'($urandom_range(0, 1));
         bus.is_branch_taken = 1'b1;
         bus.branch_target   = $urandom & ~32'h3;
         #1;
         check_eq("halt_hold_req", bus.imem_req, 0);
         check_eq("halt_hold_pc", pc, 32'h40);
         check_eq("halt_hold_flag", halted, 1);
      end
      clear_exec();
      bus.imem_gnt = 1'b0;
      stall = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_eq("halt_rst_halted", halted, 0);
      release_reset();

      // Reset mid-FETCH with grant pending
      fetch(0, 0);
      exec_op(0, 0, 1, 0, 0, 32'h300, 0, 0);
      @(negedge clk); #1;
      check_eq("pend_req", bus.imem_req, 1);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("abort_req", bus.imem_req, 0);
      check_eq("abort_issue", issue, 0);
      check_model("abort");
      release_reset();
      fetch(1, 0);
      check_eq("restart_pc", pc, 32'h0);
      exec_op(0, 0, 0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
